multicycle_ctrl: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back over several clocks on a shared ALU and a single memory port. Each cycle it drives the datapath muxes, register-file and memory enables, and the 4-bit ALUOp code consumed by the ALU control unit. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/write-back,
// drives datapath mux selects and enables, counts retired instructions and flags unsupported opcodes.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_IMMEXE  = 4'd8,
        S_IMMWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     state, state_next;
    logic       func_ok;
    logic       retire;
    logic [3:0] imm_aop;
    logic       imm_ext;

    always_comb begin
        case (func)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: func_ok = 1'b1;
            default:                         func_ok = 1'b0;
        endcase
    end

    // Logical immediates and lui zero-extend; everything else sign-extends.
    always_comb begin
        imm_aop = 4'b0000;
        imm_ext = 1'b1;
        case (op)
            OP_ADDIU: imm_aop = 4'b0010;
            OP_ANDI:  begin imm_aop = 4'b0011; imm_ext = 1'b0; end
            OP_LUI:   begin imm_aop = 4'b0100; imm_ext = 1'b0; end
            OP_ORI:   begin imm_aop = 4'b0101; imm_ext = 1'b0; end
            OP_SLTI:  imm_aop = 4'b0110;
            OP_SLTIU: imm_aop = 4'b0111;
            OP_XORI:  begin imm_aop = 4'b1000; imm_ext = 1'b0; end
            default:  imm_aop = 4'b0000;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_op     = 4'b0000;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (op)
                    OP_LW, OP_SW:   state_next = S_MEMADDR;
                    OP_R:           state_next = func_ok ? S_RTEXE : S_ILLEGAL;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J, OP_JAL:   state_next = S_JUMP;
                    OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: state_next = S_IMMEXE;
                    default:        state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                ext_op     = 1'b1;
                state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_RTEXE: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b1100;
                state_next = S_RTWB;
            end
            S_RTWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_IMMEXE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                ext_op     = imm_ext;
                alu_op     = imm_aop;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 4'b0001;
                pc_source  = 2'b01;
                pc_write   = (op == OP_BNE) ? ~zero : zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                if (op == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: state_next = S_ILLEGAL;
            default:   state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_ILLEGAL) illegal <= 1'b1;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    assign dbg_state = state;

endmodule
